// File: rtl/tone_sequencer.sv
// Note-table player: steps {half_period, dur} entries through PLAY/GAP timing for a square-wave tone generator.
// Optional output stage: define TONE_SEQ_OUT_EN to add the internal half-period counter and the tone_out port.
module tone_sequencer #(
  parameter int                  CLK_HZ    = 25000000,
  parameter int                  TICK_HZ   = 1000,
  parameter int                  GAP_TICKS = 20,
  parameter int                  NOTES     = 16,
  // Note table image, entry i at [i*28 +: 28] = {half_period[15:0], dur[11:0]}
  parameter logic [NOTES*28-1:0] ROM_INIT  = '0,
  localparam int                 IW        = $clog2(NOTES)
) (
  input  logic          clk_25mhz,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic          busy,
  output logic [15:0]   half_period,
  output logic          tone_en,
  output logic [IW-1:0] note_idx,
  output logic          done
`ifdef TONE_SEQ_OUT_EN
  ,
  output logic          tone_out
`endif
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [11:0]   GAP_LIM   = 12'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NOTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    PLAY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          fetch_rd_q, fetch_rd_d;
  logic          busy_q, busy_d;
  logic [15:0]   hp_q, hp_d;
  logic          tone_en_q, tone_en_d;
  logic [IW-1:0] note_idx_q, note_idx_d;
  logic          done_q, done_d;
  logic [11:0]   dur_q, dur_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [11:0]   ticks_q, ticks_d;

  logic [27:0]   rom [NOTES];
  logic [27:0]   rom_data_q;

  generate
    for (genvar gi = 0; gi < NOTES; gi++) begin : g_rom
      assign rom[gi] = ROM_INIT[gi*28 +: 28];
    end
  endgenerate

  always_ff @(posedge clk_25mhz) begin
    rom_data_q <= rom[note_idx_q];
  end

  logic [15:0] entry_hp;
  logic [11:0] entry_dur;
  logic        eval;
  logic        end_marker;
  logic        tick_wrap;
  logic [11:0] seg_lim;
  logic        seg_end;
  logic        advance;
  logic        eos;
  logic        play_entry;

  // The second FETCH cycle sees the registered ROM word; that is where the entry is evaluated.
  always_comb begin
    entry_hp   = rom_data_q[27:12];
    entry_dur  = rom_data_q[11:0];
    eval       = (state_q == FETCH) && fetch_rd_q;
    end_marker = (entry_dur == 12'd0);
    tick_wrap  = (presc_q == PRESC_MAX);
    seg_lim    = (state_q == PLAY) ? (dur_q - 12'd1) : GAP_LIM;
    seg_end    = ((state_q == PLAY) || (state_q == GAP)) && tick_wrap && (ticks_q == seg_lim);
    advance    = seg_end && ((state_q == GAP) || (GAP_TICKS == 0));
    eos        = (eval && end_marker) || (advance && (note_idx_q == LAST_IDX));
    play_entry = eval && !end_marker && !stop;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_rd_q <= 1'b0;
      busy_q     <= 1'b0;
      hp_q       <= '0;
      tone_en_q  <= 1'b0;
      note_idx_q <= '0;
      done_q     <= 1'b0;
      dur_q      <= '0;
      presc_q    <= '0;
      ticks_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_rd_q <= fetch_rd_d;
      busy_q     <= busy_d;
      hp_q       <= hp_d;
      tone_en_q  <= tone_en_d;
      note_idx_q <= note_idx_d;
      done_q     <= done_d;
      dur_q      <= dur_d;
      presc_q    <= presc_d;
      ticks_q    <= ticks_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   if (eval && !end_marker) state_d = PLAY;
        PLAY:    if (seg_end && GAP_TICKS != 0) state_d = GAP;
        default: ;
      endcase
      if (eos) begin
        state_d = loop ? FETCH : IDLE;
      end else if (advance) begin
        state_d = FETCH;
      end
    end
  end

  always_comb begin
    busy_d     = (state_d != IDLE);
    fetch_rd_d = (state_q == FETCH) && !fetch_rd_q && !stop;
    hp_d       = hp_q;
    tone_en_d  = tone_en_q;
    note_idx_d = note_idx_q;
    done_d     = 1'b0;
    dur_d      = dur_q;
    presc_d    = '0;
    ticks_d    = '0;

    if ((state_q == PLAY || state_q == GAP) && !seg_end) begin
      presc_d = tick_wrap ? '0 : presc_q + PW'(1);
      ticks_d = tick_wrap ? ticks_q + 12'd1 : ticks_q;
    end

    if (play_entry) begin
      hp_d      = entry_hp;
      tone_en_d = (entry_hp != 16'd0);
      dur_d     = entry_dur;
    end
    if (state_q == PLAY && seg_end) tone_en_d = 1'b0;

    if (stop) begin
      hp_d      = '0;
      tone_en_d = 1'b0;
    end else if (state_q == IDLE && start) begin
      note_idx_d = '0;
    end else if (eos) begin
      if (loop) note_idx_d = '0;
      else      done_d     = 1'b1;
    end else if (advance) begin
      note_idx_d = note_idx_q + IW'(1);
    end
  end

  assign busy        = busy_q;
  assign half_period = hp_q;
  assign tone_en     = tone_en_q;
  assign note_idx    = note_idx_q;
  assign done        = done_q;

`ifdef TONE_SEQ_OUT_EN
  logic [15:0] hc_q, hc_d;
  logic        tone_q, tone_d;

  // tone_out follows tone_en_d so it drops on the same edge the note ends or stop hits.
  always_comb begin
    hc_d   = hc_q;
    tone_d = tone_q;
    if (play_entry) begin
      hc_d   = entry_hp - 16'd1;
      tone_d = 1'b0;
    end else if (state_q == PLAY && tone_en_q) begin
      if (hc_q == 16'd0) begin
        hc_d   = hp_q - 16'd1;
        tone_d = !tone_q;
      end else begin
        hc_d = hc_q - 16'd1;
      end
    end
    if (!tone_en_d) tone_d = 1'b0;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      hc_q   <= '0;
      tone_q <= 1'b0;
    end else begin
      hc_q   <= hc_d;
      tone_q <= tone_d;
    end
  end

  assign tone_out = tone_q;
`endif

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: DIV=10, GAP_TICKS=2, NOTES=4, one terminated melody and one full table.
module tb_tone_sequencer;

  localparam logic [4*28-1:0] ROM_MEL  = {28'h0000000, 28'h0007001, 28'h0000002, 28'h0005003};
  localparam logic [4*28-1:0] ROM_FULL = {28'h0003001, 28'h0003001, 28'h0003001, 28'h0003001};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;

  logic        busy1, tone_en1, done1;
  logic [15:0] hp1;
  logic [1:0]  idx1;
  logic        busy2, tone_en2, done2;
  logic [15:0] hp2;
  logic [1:0]  idx2;
`ifdef TONE_SEQ_OUT_EN
  logic        tone_out1, tone_out2;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(2), .NOTES(4), .ROM_INIT(ROM_MEL)
  ) u_dut (
    .clk_25mhz(clk), .reset(reset), .start(start1), .stop(stop), .loop(loop),
    .busy(busy1), .half_period(hp1), .tone_en(tone_en1), .note_idx(idx1), .done(done1)
`ifdef TONE_SEQ_OUT_EN
    , .tone_out(tone_out1)
`endif
  );

  tone_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .GAP_TICKS(2), .NOTES(4), .ROM_INIT(ROM_FULL)
  ) u_dut_full (
    .clk_25mhz(clk), .reset(reset), .start(start2), .stop(stop), .loop(loop),
    .busy(busy2), .half_period(hp2), .tone_en(tone_en2), .note_idx(idx2), .done(done2)
`ifdef TONE_SEQ_OUT_EN
    , .tone_out(tone_out2)
`endif
  );

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Cycle 0 is the cycle whose closing edge samples the start pulse.
  task automatic kick(input logic which, input logic with_stop);
    if (which) start2 = 1'b1; else start1 = 1'b1;
    stop = with_stop;
    cyc = 0;
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
    stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_hp", 32'(hp1), 32'd0);
    chk("rst_tone_en", 32'(tone_en1), 32'd0);
    chk("rst_idx", 32'(idx1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);

    // Melody, loop=0, with a stray start while busy
    kick(1'b0, 1'b0);
    wait_to(2);  chk("m_fetch_busy", 32'(busy1), 32'd1);
                 chk("m_fetch_ten", 32'(tone_en1), 32'd0);
    wait_to(3);  chk("m_n0_ten", 32'(tone_en1), 32'd1);
                 chk("m_n0_hp", 32'(hp1), 32'd5);
                 chk("m_n0_idx", 32'(idx1), 32'd0);
    wait_to(5);  start1 = 1'b1; tick(); start1 = 1'b0;
    wait_to(32); chk("m_n0_last", 32'(tone_en1), 32'd1);
                 chk("m_n0_hp_hold", 32'(hp1), 32'd5);
    wait_to(33); chk("m_gap0_ten", 32'(tone_en1), 32'd0);
                 chk("m_gap0_busy", 32'(busy1), 32'd1);
    wait_to(55); chk("m_rest_idx", 32'(idx1), 32'd1);
                 chk("m_rest_hp", 32'(hp1), 32'd0);
                 chk("m_rest_ten", 32'(tone_en1), 32'd0);
    wait_to(96); chk("m_n2_pre", 32'(tone_en1), 32'd0);
    wait_to(97); chk("m_n2_ten", 32'(tone_en1), 32'd1);
                 chk("m_n2_hp", 32'(hp1), 32'd7);
                 chk("m_n2_idx", 32'(idx1), 32'd2);
    wait_to(106); chk("m_n2_last", 32'(tone_en1), 32'd1);
    wait_to(107); chk("m_gap2_ten", 32'(tone_en1), 32'd0);
    wait_to(128); chk("m_eval_done", 32'(done1), 32'd0);
                  chk("m_eval_busy", 32'(busy1), 32'd1);
    wait_to(129); chk("m_done", 32'(done1), 32'd1);
                  chk("m_end_busy", 32'(busy1), 32'd0);
                  chk("m_end_idx", 32'(idx1), 32'd3);
    wait_to(130); chk("m_done_pulse", 32'(done1), 32'd0);

    // Melody, loop=1, then stop 5 cycles into entry 0 of the second pass
    tick(); tick();
    loop = 1'b1;
    kick(1'b0, 1'b0);
    wait_to(129); chk("l_no_done", 32'(done1), 32'd0);
                  chk("l_busy", 32'(busy1), 32'd1);
                  chk("l_idx0", 32'(idx1), 32'd0);
    wait_to(131); chk("l_n0_ten", 32'(tone_en1), 32'd1);
                  chk("l_n0_hp", 32'(hp1), 32'd5);
    wait_to(136); stop = 1'b1; tick(); stop = 1'b0;
    chk("s_ten", 32'(tone_en1), 32'd0);
    chk("s_hp", 32'(hp1), 32'd0);
    chk("s_busy", 32'(busy1), 32'd0);
    loop = 1'b0;
    tick(); chk("s_no_done", 32'(done1), 32'd0);

    // start and stop together from IDLE
    tick();
    kick(1'b0, 1'b1);
    wait_to(2); chk("ss_busy", 32'(busy1), 32'd0);
    wait_to(3); chk("ss_ten", 32'(tone_en1), 32'd0);

    // Full table, no end marker: wraps to end-of-sequence after idx 3
    tick();
    kick(1'b1, 1'b0);
    wait_to(3);   chk("f_n0_ten", 32'(tone_en2), 32'd1);
                  chk("f_n0_hp", 32'(hp2), 32'd3);
    wait_to(35);  chk("f_idx1", 32'(idx2), 32'd1);
    wait_to(67);  chk("f_idx2", 32'(idx2), 32'd2);
    wait_to(99);  chk("f_idx3", 32'(idx2), 32'd3);
                  chk("f_n3_ten", 32'(tone_en2), 32'd1);
    wait_to(128); chk("f_pre_done", 32'(done2), 32'd0);
    wait_to(129); chk("f_done", 32'(done2), 32'd1);
                  chk("f_busy", 32'(busy2), 32'd0);
                  chk("f_idx_hold", 32'(idx2), 32'd3);

    // Reset while entry 1 of the full table plays
    tick();
    kick(1'b1, 1'b0);
    wait_to(40); chk("r_pre_idx", 32'(idx2), 32'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("r_busy", 32'(busy2), 32'd0);
    chk("r_ten", 32'(tone_en2), 32'd0);
    chk("r_hp", 32'(hp2), 32'd0);
    chk("r_idx", 32'(idx2), 32'd0);
    chk("r_done", 32'(done2), 32'd0);

`ifdef TONE_SEQ_OUT_EN
    tick();
    kick(1'b0, 1'b0);
    wait_to(3);  chk("t_c3", 32'(tone_out1), 32'd0);
    wait_to(7);  chk("t_c7", 32'(tone_out1), 32'd0);
    wait_to(8);  chk("t_c8", 32'(tone_out1), 32'd1);
    wait_to(12); chk("t_c12", 32'(tone_out1), 32'd1);
    wait_to(13); chk("t_c13", 32'(tone_out1), 32'd0);
    wait_to(18); chk("t_c18", 32'(tone_out1), 32'd1);
    wait_to(32); chk("t_c32", 32'(tone_out1), 32'd1);
    wait_to(33); chk("t_gap", 32'(tone_out1), 32'd0);
    wait_to(60); chk("t_rest", 32'(tone_out1), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
